// File: rtl/register_dump_unit_pkg.sv
// ============================================================================
// regdump_pkg
// Shared definitions for the register dump unit: the FSM state encoding,
// the default geometry of the register bank, and the derived constants that
// the top, the serializer and the testbench all agree on.
// ============================================================================
package regdump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_SEND,
        ST_CHK,
        ST_DONE
    } state_t;

    localparam int REG_WIDTH_DEF     = 32;
    localparam int REG_ADDR_BITS_DEF = 5;
    localparam int BYTE_WIDTH_DEF    = 8;

    localparam int BYTES_PER_REG = REG_WIDTH_DEF / BYTE_WIDTH_DEF;
    localparam int NUM_REGS      = 2 ** REG_ADDR_BITS_DEF;

    // Byte counters need at least one bit even when a word is a single byte.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/register_dump_unit_word_serializer.sv
// ============================================================================
// word_serializer
// Loads one bank word and streams it out MSB byte first over valid/ready.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         one-cycle pulse: capture load_word and start presenting bytes
//   load_word    word to serialize
//   byte_data    current byte (top BYTE_WIDTH bits of the shift register)
//   byte_valid   byte_data is valid; held until accepted
//   byte_ready   consumer accepts when byte_valid && byte_ready at posedge
//   byte_taken   a handshake happens at the coming posedge
//   last_byte    the byte currently presented is the final byte of the word
// ============================================================================
module word_serializer
    import regdump_pkg::*;
#(
    parameter int WORD_WIDTH = REG_WIDTH_DEF,
    parameter int BYTE_WIDTH = BYTE_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [WORD_WIDTH-1:0] load_word,
    output logic [BYTE_WIDTH-1:0] byte_data,
    output logic                  byte_valid,
    input  logic                  byte_ready,
    output logic                  byte_taken,
    output logic                  last_byte
);

    localparam int NBYTES = WORD_WIDTH / BYTE_WIDTH;
    localparam int IDX_W  = idx_width(NBYTES);

    logic [WORD_WIDTH-1:0] shift_reg;
    logic [IDX_W-1:0]      byte_idx;
    logic                  valid_q;

    assign byte_valid = valid_q;
    assign byte_data  = shift_reg[WORD_WIDTH-1 -: BYTE_WIDTH];
    assign byte_taken = valid_q & byte_ready;
    assign last_byte  = (byte_idx == IDX_W'(NBYTES - 1));

    // The presented byte is always the top of the shift register, so it
    // stays stable until a handshake moves the next byte up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            byte_idx  <= '0;
            valid_q   <= 1'b0;
        end else if (load) begin
            shift_reg <= load_word;
            byte_idx  <= '0;
            valid_q   <= 1'b1;
        end else if (byte_taken) begin
            if (last_byte) begin
                valid_q  <= 1'b0;
                byte_idx <= '0;
            end else begin
                shift_reg <= shift_reg << BYTE_WIDTH;
                byte_idx  <= byte_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/register_dump_unit.sv
// ============================================================================
// register_dump_unit
// Debug-side reader for the register bank. A start pulse walks every bank
// register through the debug read port and streams each word, big-endian,
// as bytes towards the debug UART transmitter. busy freezes the pipeline
// while a dump is in progress.
//
// Optional feature (macro REGDUMP_CHECKSUM_EN): a running XOR of every byte
// sent is appended as one extra byte after the last register.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        one-cycle dump request, ignored unless idle
//   busy         dump in progress
//   done         one-cycle pulse after the last byte was accepted
//   rd_addr      registered address to the bank debug read port
//   rd_data      bank data, valid one cycle after rd_addr changes
//   tx_data      byte to the transmitter
//   tx_valid     tx_data valid
//   tx_ready     transmitter accepts on tx_valid && tx_ready at posedge
// ============================================================================
module register_dump_unit
    import regdump_pkg::*;
#(
    parameter int REG_WIDTH     = REG_WIDTH_DEF,
    parameter int REG_ADDR_BITS = REG_ADDR_BITS_DEF,
    parameter int BYTE_WIDTH    = BYTE_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [REG_ADDR_BITS-1:0] rd_addr,
    input  logic [REG_WIDTH-1:0]     rd_data,
    output logic [BYTE_WIDTH-1:0]    tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready
);

    if (REG_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("REG_WIDTH must be a multiple of BYTE_WIDTH");
    end

    state_t                state, state_next;
    logic                  ser_load;
    logic [BYTE_WIDTH-1:0] ser_data;
    logic                  ser_valid;
    logic                  ser_taken;
    logic                  ser_last;
    logic                  addr_last;
    logic                  word_done;

    assign addr_last = &rd_addr;
    assign word_done = (state == ST_SEND) && ser_taken && ser_last;

    word_serializer #(
        .WORD_WIDTH (REG_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH)
    ) u_serializer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (ser_load),
        .load_word  (rd_data),
        .byte_data  (ser_data),
        .byte_valid (ser_valid),
        .byte_ready (tx_ready),
        .byte_taken (ser_taken),
        .last_byte  (ser_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ADDR lasts one cycle: the bank returns data for rd_addr on the
    // negedge, so the serializer can load it at the following posedge.
    always_comb begin
        state_next = state;
        ser_load   = 1'b0;
        case (state)
            ST_IDLE: if (start) state_next = ST_ADDR;
            ST_ADDR: begin
                ser_load   = 1'b1;
                state_next = ST_SEND;
            end
            ST_SEND: begin
                if (word_done) begin
`ifdef REGDUMP_CHECKSUM_EN
                    state_next = addr_last ? ST_CHK : ST_ADDR;
`else
                    state_next = addr_last ? ST_DONE : ST_ADDR;
`endif
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            ST_CHK:  if (tx_ready) state_next = ST_DONE;
`endif
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // The last register is all-ones, so the address never wraps inside a
    // dump; it is parked back at 0 on the way out through DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr <= '0;
        end else if ((state == ST_IDLE) && start) begin
            rd_addr <= '0;
        end else if (word_done && !addr_last) begin
            rd_addr <= rd_addr + 1'b1;
        end else if (state == ST_DONE) begin
            rd_addr <= '0;
        end
    end

    assign busy = (state == ST_ADDR) || (state == ST_SEND) || (state == ST_CHK);
    assign done = (state == ST_DONE);

`ifdef REGDUMP_CHECKSUM_EN
    logic [BYTE_WIDTH-1:0] checksum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if ((state == ST_IDLE) && start) begin
            checksum <= '0;
        end else if (ser_taken) begin
            checksum <= checksum ^ ser_data;
        end
    end

    assign tx_valid = ser_valid || (state == ST_CHK);
    assign tx_data  = (state == ST_CHK) ? checksum : ser_data;
`else
    assign tx_valid = ser_valid;
    assign tx_data  = ser_data;
`endif

endmodule

// File: tb/tb_register_dump_unit.sv
// ============================================================================
// tb_register_dump_unit
// Scoreboard bench: each dump pushes its expected byte stream into a queue,
// and a negedge monitor pops and compares on every transmitter handshake.
// Handles both builds (with or without REGDUMP_CHECKSUM_EN).
// ============================================================================
module tb_register_dump_unit;
    import regdump_pkg::*;

    localparam int RW    = 32;
    localparam int AB    = 5;
    localparam int BW    = 8;
    localparam int NREGS = NUM_REGS;
`ifdef REGDUMP_CHECKSUM_EN
    localparam int LAST_TO_DONE = 161;
`else
    localparam int LAST_TO_DONE = 160;
`endif

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic [AB-1:0] rd_addr;
    logic [RW-1:0] rd_data;
    logic [BW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;

    logic [RW-1:0] bank [NREGS];
    logic [BW-1:0] exp_q [$];
    logic [BW-1:0] exp_byte;
    logic [BW-1:0] hold_data;
    logic          hold_prev;
    int            tests;
    int            fails;
    int            bytes_seen;
    int            done_count;
    int            cyc;

    register_dump_unit #(
        .REG_WIDTH     (RW),
        .REG_ADDR_BITS (AB),
        .BYTE_WIDTH    (BW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank debug port model: samples rd_addr on the falling edge.
    always @(negedge clk) rd_data <= bank[rd_addr];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: byte scoreboard, hold-stability check and done counting.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                tests++;
                if (!(tx_valid && tx_data == hold_data)) begin
                    fails++;
                    $display("[TB] FAIL hold_stable: got valid=%0b data=%h, need valid=1 data=%h",
                             tx_valid, tx_data, hold_data);
                end
            end
            if (done) done_count++;
            if (tx_valid && tx_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL extra_byte: got %h, need no byte", tx_data);
                end else begin
                    exp_byte = exp_q.pop_front();
                    if (tx_data !== exp_byte) begin
                        fails++;
                        $display("[TB] FAIL byte_%0d: got %h, need %h", bytes_seen, tx_data, exp_byte);
                    end
                end
                bytes_seen++;
            end
            hold_prev = tx_valid && !tx_ready;
            hold_data = tx_data;
        end
    end

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] need);
        tests++;
        if (got !== need) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, need %0h", name, got, need);
        end
    endtask

    task automatic push_expected(input logic [BW-1:0] csum);
        for (int r = 0; r < NREGS; r++)
            for (int b = 0; b < BYTES_PER_REG; b++)
                exp_q.push_back(bank[r][(RW-1-BW*b) -: BW]);
`ifdef REGDUMP_CHECKSUM_EN
        exp_q.push_back(csum);
`else
        if (csum != csum) exp_q.push_back(csum);
`endif
    endtask

    task automatic drive_ready(input int ready_mode);
        tx_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
    endtask

    // One full dump; returns in the DONE cycle, 1 time unit after the edge.
    task automatic applyStimulus(input int ready_mode, input bit repulse, input logic [BW-1:0] csum);
        int start_cyc;
        bit got;
        push_expected(csum);
        @(posedge clk); #1;
        start = 1'b1;
        drive_ready(ready_mode);
        @(posedge clk); #1;
        start     = 1'b0;
        start_cyc = cyc;
        check_val("busy_after_start", 32'(busy), 32'd1);
        got = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            drive_ready(ready_mode);
            start = repulse && (k == 5 || k == 90);
            @(posedge clk); #1;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check_val("done_seen", 32'(got), 32'd1);
        if (got) begin
            check_val("busy_in_done", 32'(busy), 32'd0);
            if (ready_mode == 0)
                check_val("done_latency", 32'(cyc - start_cyc), 32'(LAST_TO_DONE));
        end
    endtask

    task automatic checkOutput(input int exp_dones);
        repeat (4) @(posedge clk);
        #1;
        check_val("queue_drained", 32'(exp_q.size()), 32'd0);
        check_val("done_count", 32'(done_count), 32'(exp_dones));
        check_val("idle_busy", 32'(busy), 32'd0);
        check_val("idle_rd_addr", 32'(rd_addr), 32'd0);
        check_val("idle_tx_valid", 32'(tx_valid), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_done"}, 32'(done), 32'd0);
        check_val({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        check_val({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    endtask

    task automatic reset_mid_dump();
        int base;
        bit reached;
        push_expected(8'h00);
        base = bytes_seen;
        @(posedge clk); #1;
        start    = 1'b1;
        tx_ready = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        reached = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (bytes_seen - base >= 50) begin
                reached = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check_val("reached_byte_50", 32'(reached), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        @(posedge clk); #3;
        rst_n = 1'b1;
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        bytes_seen = 0;
        done_count = 0;
        cyc        = 0;
        hold_prev  = 1'b0;
        hold_data  = '0;
        start      = 1'b0;
        tx_ready   = 1'b0;
        rst_n      = 1'b0;
        for (int i = 0; i < NREGS; i++) bank[i] = 32'h01020300 + 32'(i);

        #12;
        check_reset_outputs("por");
        #5 rst_n = 1'b1;

        $display("[TB] ramp pattern, tx_ready high");
        applyStimulus(0, 1'b0, 8'h00);
        checkOutput(1);

        $display("[TB] ramp pattern, tx_ready 1-in-3");
        applyStimulus(1, 1'b0, 8'h00);
        checkOutput(2);

        $display("[TB] start re-pulsed during dump");
        applyStimulus(0, 1'b1, 8'h00);
        checkOutput(3);

        $display("[TB] reset at byte 50, then full dump");
        reset_mid_dump();
        applyStimulus(0, 1'b0, 8'h00);
        checkOutput(4);

        $display("[TB] back-to-back dumps");
        applyStimulus(0, 1'b0, 8'h00);
        applyStimulus(0, 1'b0, 8'h00);
        checkOutput(6);

        $display("[TB] all-ones registers");
        for (int i = 0; i < NREGS; i++) bank[i] = 32'hFFFFFFFF;
        applyStimulus(1, 1'b0, 8'h00);
        checkOutput(7);

        $display("[TB] single AA byte in register 0");
        for (int i = 0; i < NREGS; i++) bank[i] = 32'h0;
        bank[0] = 32'h000000AA;
        applyStimulus(0, 1'b0, 8'hAA);
        checkOutput(8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
